// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one physical memory port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of D-over-I priority.
module cache_arbiter (
    input  logic         clk,
    input  logic         reset,

    input  logic         i_pmem_read,
    input  logic [15:0]  i_pmem_address,
    output logic [127:0] i_pmem_rdata,
    output logic         i_pmem_resp,

    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [15:0]  d_pmem_address,
    input  logic [127:0] d_pmem_wdata,
    output logic [127:0] d_pmem_rdata,
    output logic         d_pmem_resp,

    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,

    output logic         arb_busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SERVE_I = 2'b01,
        ST_SERVE_D = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_d_req;
    logic   w_grant_d;

    assign w_d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_d;

    // Last-served tracker, updated only when memory completes a service
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d <= 1'b1;
        end else if ((r_state == ST_SERVE_D) && pmem_resp) begin
            r_last_d <= 1'b1;
        end else if ((r_state == ST_SERVE_I) && pmem_resp) begin
            r_last_d <= 1'b0;
        end else begin
            r_last_d <= r_last_d;
        end
    end

    // On contention, D wins only if I was served last
    assign w_grant_d = w_d_req & (~i_pmem_read | ~r_last_d);
`else
    assign w_grant_d = w_d_req;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: completion or a withdrawn request both return to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_next = ST_SERVE_D;
                end else if (i_pmem_read) begin
                    w_state_next = ST_SERVE_I;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SERVE_I: begin
                if (pmem_resp || !i_pmem_read) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SERVE_I;
                end
            end
            ST_SERVE_D: begin
                if (pmem_resp || !w_d_req) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SERVE_D;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output steering: strobes and resp follow the granted requester combinationally
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 128'h0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        arb_busy     = 1'b0;
        case (r_state)
            ST_SERVE_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
                arb_busy     = 1'b1;
            end
            ST_SERVE_D: begin
                pmem_write   = d_pmem_write;
                pmem_read    = d_pmem_read & ~d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
                arb_busy     = 1'b1;
            end
            ST_IDLE: begin
                arb_busy     = 1'b0;
            end
            default: begin
                arb_busy     = 1'b0;
            end
        endcase
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_pmem_read  in  1  I-cache line-fill request; level, held until i_pmem_resp.
- i_pmem_address  in  16  I-cache line address.
- i_pmem_rdata  out  128  line data to I-cache.
- i_pmem_resp  out  1  one-cycle completion pulse to I-cache.
- d_pmem_read  in  1  D-cache fill request; level, held until d_pmem_resp.
- d_pmem_write  in  1  D-cache writeback request; level, held until d_pmem_resp.
- d_pmem_address  in  16  D-cache line address.
- d_pmem_wdata  in  128  writeback line data.
- d_pmem_rdata  out  128  line data to D-cache.
- d_pmem_resp  out  1  one-cycle completion pulse to D-cache.
- pmem_read  out  1  read strobe to physical memory.
- pmem_write  out  1  write strobe to physical memory.
- pmem_address  out  16  physical memory address.
- pmem_wdata  out  128  physical memory write data.
- pmem_rdata  in  128  physical memory read data.
- pmem_resp  in  1  physical memory completion pulse.
- arb_busy  out  1  high while any request is being served.

Function
REQ-002 The FSM SHALL have exactly three states: IDLE, SERVE_I, SERVE_D; state is registered.
REQ-003 IDLE: if D request (d_pmem_read or d_pmem_write) is high, next state SERVE_D; else if i_pmem_read is high, SERVE_I; else IDLE.
REQ-004 Grant latency SHALL be exactly one cycle: a request first seen in IDLE at cycle N drives pmem strobes from cycle N+1.
REQ-005 In IDLE, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp and arb_busy SHALL be 0.
REQ-006 SERVE_D: pmem_write = d_pmem_write; pmem_read = d_pmem_read and not d_pmem_write; pmem_address = d_pmem_address; pmem_wdata = d_pmem_wdata; d_pmem_resp = pmem_resp (combinational); arb_busy = 1.
REQ-007 SERVE_I: pmem_read = i_pmem_read; pmem_write = 0; pmem_address = i_pmem_address; i_pmem_resp = pmem_resp (combinational); arb_busy = 1.
REQ-008 i_pmem_rdata and d_pmem_rdata SHALL both be driven by pmem_rdata at all times; only the resp pulse qualifies them.
REQ-009 On pmem_resp high in SERVE_x, next state SHALL be IDLE, giving one bubble cycle before any new grant.
REQ-010 The non-granted requester's resp SHALL stay 0 for the whole service of the other requester, including when pmem_resp pulses.
REQ-011 If the granted requester drops its request before pmem_resp, the FSM SHALL return to IDLE next cycle; strobes follow the request level and go low in the same cycle.
REQ-012 pmem_resp received in IDLE SHALL be ignored: no resp output, no state change.
REQ-013 pmem_address and pmem_wdata in IDLE SHALL be 0.

Reset
REQ-014 With reset high at a rising edge, state SHALL become IDLE and the last-served register (REQ-016) SHALL become D; all outputs SHALL then follow IDLE values.
REQ-015 Reset asserted mid-service SHALL abort the transaction: strobes go low the cycle after the reset edge, and no resp is issued for the aborted request.

Configuration
REQ-016 Macro ARB_ROUND_ROBIN_EN defined: a last-served register (I or D) SHALL update on each completed service, and in IDLE with both requests high the grant SHALL go to the requester not last served.
REQ-017 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, D over I per REQ-003, and no last-served register.

Verification
REQ-018 Fill only I: i_pmem_read=1, addr 0x1230; pmem_resp after 3 cycles with rdata 0xA5..A5 -> pmem_read=1 and pmem_address=0x1230 from cycle 1; i_pmem_resp=1 for one cycle with i_pmem_rdata=0xA5..A5; next cycle IDLE.
REQ-019 Simultaneous I read 0x0040 and D write 0x0080, fixed priority -> D served first (pmem_write=1, addr 0x0080); after d_pmem_resp, one bubble cycle, then I served at 0x0040.
REQ-020 Same stimulus as REQ-019 with ARB_ROUND_ROBIN_EN defined and last-served = D -> I served first, then D; repeating both requests alternates the grant order.
REQ-021 Reset asserted in cycle 2 of a D read at 0x00F0 -> pmem_read=0 next cycle; d_pmem_resp never pulses; a later pmem_resp is ignored.
REQ-022 d_pmem_read and d_pmem_write both 1 -> pmem_write=1, pmem_read=0; a pmem_resp pulse in IDLE produces no resp output.
